cache_cmd_sequencer: RTL
========================

# cache_cmd_sequencer

Command sequencer between the OBI register block and the cache core. It accepts one command per CTR write: it latches operation, key and data from the register-read snapshot, issues a single request to the cache core and waits for completion. It then writes busy, hit, operation and data back through the `reg_write_t` write-back port. Exactly one command is in flight at any time.

## Interface
Parameters:
- `KeyWidth`, default `cache_cfg_pkg::KEY_WIDTH`: key width in bits.
- `ValueWidth`, default `cache_cfg_pkg::VALUE_WIDTH`: data width in bits.
- `TimeoutCycles`, default 1024: WAIT-state watchdog limit. Used only when `CACHE_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse from the register block when CTR is written.
- `reg_read_i`  in  `$bits(reg_read_t)`  current DAT/KEY/operation register contents.
- `reg_write_o`  out  `$bits(reg_write_t)`  register write-back; each `*_valid` bit is a one-cycle pulse.
- `core_req_o`  out  1  request to the cache core; held until granted.
- `core_gnt_i`  in  1  cache core accepts the request.
- `core_op_o`  out  `operation_e`  latched operation.
- `core_key_o`  out  KeyWidth  latched key.
- `core_data_o`  out  ValueWidth  latched write data.
- `core_done_i`  in  1  completion pulse from the cache core.
- `core_hit_i`  in  1  hit result; valid with `core_done_i`.
- `core_rdata_i`  in  ValueWidth  read data; valid with `core_done_i`.
- `timeout_o`  out  1  one-cycle pulse when the watchdog aborts a command.

## Operation
States: IDLE, ISSUE, WAIT, WRITEBACK.

- **IDLE**
  - `start_i` with an operation other than NOOP: latch op, key and data; go to ISSUE.
  - `start_i` with NOOP: ignored; no write-back.
- **ISSUE**
  - `core_req_o`=1.
  - On `core_gnt_i`: go to WAIT.
  - If `core_gnt_i` and `core_done_i` arrive in the same cycle: go directly to WRITEBACK and capture the result.
- **WAIT**
  - On `core_done_i`: capture hit and rdata; go to WRITEBACK.
  - A `core_done_i` seen outside ISSUE or WAIT is ignored.
- **WRITEBACK** (one cycle): pulse all of the following, then return to IDLE.
  - `busy_valid`=1 with busy=0.
  - `hit_valid`=1 with the captured hit.
  - `operation_valid`=1 with operation=NOOP.
  - `data_valid`=1 only for READ with hit=1; `dat` carries the captured rdata.
- **Busy set**: on the IDLE→ISSUE transition, `reg_write_o` pulses `busy_valid`=1, busy=1.
- **Start while not IDLE**: `start_i` is dropped silently and the latched command is unchanged.
- **Stable core inputs**: `core_op_o`, `core_key_o` and `core_data_o` stay stable from ISSUE through WRITEBACK.
- **Reset** (any state): state returns to IDLE; all outputs 0, including every `reg_write_o` field; latched registers 0. An in-flight request is abandoned without a write-back.

## Timing
- All outputs are registered except `core_req_o`, `core_op_o`, `core_key_o` and `core_data_o`, which decode from state and the latches.
- Cycle-level latency, with `start_i` in cycle 0:
  - Cycle 1: busy-set pulse, state ISSUE, `core_req_o`=1.
  - Grant in cycle g: WAIT from cycle g+1.
  - Done in cycle d: WRITEBACK pulse in cycle d+1, IDLE in cycle d+2.
- Minimum start-to-write-back latency: 2 cycles (grant and done in cycle 1).
- The earliest next accepted `start_i` is in cycle d+2.

## Configuration
- `CACHE_SEQ_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TimeoutCycles+1)` clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches `TimeoutCycles` without `core_done_i`: go to WRITEBACK with hit=0, `data_valid`=0 and a `timeout_o` pulse in the WRITEBACK cycle.
  - If `core_done_i` arrives in the same cycle the limit is reached, done wins and there is no timeout.
- Not defined: no counter is built, `timeout_o` is tied to 0, and WAIT lasts indefinitely.

## Structure
- `seq_state_e` (2-bit enum IDLE/ISSUE/WAIT/WRITEBACK) belongs in `ctrl_types_pkg` next to `operation_e`.
- `reg_read_t` and `reg_write_t` come from `if_types_pkg`; no new structs are needed.
- Sub-module `cache_seq_watchdog` (counter, clear, expire) is instantiated only under `CACHE_SEQ_TIMEOUT_EN`.

## Test plan
- **Reset values**: hold `rst_ni`=0 → all outputs 0. Release, with no `start_i` → state stays IDLE and `core_req_o`=0.
- **READ hit**:
  - Stimulus: key=0x1234, start, grant in cycle 1, done in cycle 4 with hit=1, rdata=0xDEADBEEF.
  - Required response: busy pulse in cycle 1; WRITEBACK in cycle 5 with `data_valid`=1, dat=0xDEADBEEF, hit=1, busy=0.
- **UPSERT**:
  - Stimulus: data=0xA5A5, grant delayed 3 cycles.
  - Required response: `core_req_o` held for 3 cycles with `core_data_o`=0xA5A5 stable throughout; write-back has `data_valid`=0.
- **Same-cycle grant and done, then start while busy**:
  - Stimulus: DELETE with grant and done in the same cycle; a second `start_i` during ISSUE.
  - Required response: write-back is 2 cycles after start; the second start is ignored and the latched key is unchanged.
- **Timeout** (macro on, `TimeoutCycles`=8): no `core_done_i` after grant → `timeout_o`, hit=0 and busy=0 in the WRITEBACK cycle 9 cycles after entering WAIT.
- **Reset in WAIT**: assert `rst_ni`=0 during WAIT → next cycle IDLE with no write-back pulse; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/cache_cfg_pkg.sv
// Shared packages for the cache command path: configured widths, control
// enums and the register-block interface structs.
package cache_cfg_pkg;
    localparam int unsigned KEY_WIDTH   = 16;
    localparam int unsigned VALUE_WIDTH = 32;
endpackage

package ctrl_types_pkg;
    typedef enum logic [1:0] {
        OP_NOOP   = 2'd0,
        OP_READ   = 2'd1,
        OP_UPSERT = 2'd2,
        OP_DELETE = 2'd3
    } operation_e;

    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_ISSUE     = 2'd1,
        SEQ_WAIT      = 2'd2,
        SEQ_WRITEBACK = 2'd3
    } seq_state_e;
endpackage

package if_types_pkg;
    import cache_cfg_pkg::*;
    import ctrl_types_pkg::*;

    typedef struct packed {
        logic [VALUE_WIDTH-1:0] dat;
        logic [KEY_WIDTH-1:0]   key;
        operation_e             operation;
    } reg_read_t;

    // Each *_valid bit qualifies the field that follows it.
    typedef struct packed {
        logic                   busy_valid;
        logic                   busy;
        logic                   hit_valid;
        logic                   hit;
        logic                   operation_valid;
        operation_e             operation;
        logic                   data_valid;
        logic [VALUE_WIDTH-1:0] dat;
    } reg_write_t;
endpackage

// File: rtl/cache_seq_watchdog.sv
// WAIT-state watchdog for cache_cmd_sequencer; only instantiated when
// CACHE_SEQ_TIMEOUT_EN is defined.
module cache_seq_watchdog #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == CntWidth'(TimeoutCycles));
endmodule

// File: rtl/cache_cmd_sequencer.sv
// Runs one cache command per CTR write and writes the result back to the
// register block. Optional WAIT watchdog enabled by CACHE_SEQ_TIMEOUT_EN.
module cache_cmd_sequencer
    import cache_cfg_pkg::*;
    import ctrl_types_pkg::*;
    import if_types_pkg::*;
#(
    parameter int unsigned KeyWidth      = KEY_WIDTH,
    parameter int unsigned ValueWidth    = VALUE_WIDTH,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  reg_read_t             reg_read_i,
    output reg_write_t            reg_write_o,
    output logic                  core_req_o,
    input  logic                  core_gnt_i,
    output operation_e            core_op_o,
    output logic [KeyWidth-1:0]   core_key_o,
    output logic [ValueWidth-1:0] core_data_o,
    input  logic                  core_done_i,
    input  logic                  core_hit_i,
    input  logic [ValueWidth-1:0] core_rdata_i,
    output logic                  timeout_o
);
    seq_state_e            state_q, state_d;
    operation_e            op_q;
    logic [KeyWidth-1:0]   key_q;
    logic [ValueWidth-1:0] data_q;
    reg_write_t            wb_d;
    logic                  timeout_d;
    logic                  accept;
    logic                  finish;
    logic                  timed_out;
    logic                  wd_expired;

`ifdef CACHE_SEQ_TIMEOUT_EN
    logic wd_clear;
    assign wd_clear = (state_q == SEQ_ISSUE) && core_gnt_i && !core_done_i;

    cache_seq_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (wd_clear),
        .count_en_i (state_q == SEQ_WAIT),
        .expired_o  (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        wb_d      = '0;
        timeout_d = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start_i && reg_read_i.operation != OP_NOOP) begin
                    accept          = 1'b1;
                    state_d         = SEQ_ISSUE;
                    wb_d.busy_valid = 1'b1;
                    wb_d.busy       = 1'b1;
                end
            end
            SEQ_ISSUE: begin
                if (core_gnt_i) begin
                    if (core_done_i) finish  = 1'b1;
                    else             state_d = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                // A completion on the limit cycle takes precedence over expiry.
                if (core_done_i) begin
                    finish = 1'b1;
                end else if (wd_expired) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end
            end
            SEQ_WRITEBACK: state_d = SEQ_IDLE;
            default:       state_d = SEQ_IDLE;
        endcase

        if (finish) begin
            state_d              = SEQ_WRITEBACK;
            wb_d.busy_valid      = 1'b1;
            wb_d.busy            = 1'b0;
            wb_d.hit_valid       = 1'b1;
            wb_d.hit             = core_hit_i && !timed_out;
            wb_d.operation_valid = 1'b1;
            wb_d.operation       = OP_NOOP;
            wb_d.data_valid      = (op_q == OP_READ) && core_hit_i && !timed_out;
            wb_d.dat             = timed_out ? '0 : VALUE_WIDTH'(core_rdata_i);
            timeout_d            = timed_out;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEQ_IDLE;
            op_q        <= OP_NOOP;
            key_q       <= '0;
            data_q      <= '0;
            reg_write_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_write_o <= wb_d;
            timeout_o   <= timeout_d;
            if (accept) begin
                op_q   <= reg_read_i.operation;
                key_q  <= KeyWidth'(reg_read_i.key);
                data_q <= ValueWidth'(reg_read_i.dat);
            end
        end
    end

    assign core_req_o  = (state_q == SEQ_ISSUE);
    assign core_op_o   = op_q;
    assign core_key_o  = key_q;
    assign core_data_o = data_q;
endmodule
